snake_head_driver: RTL

- Generates snake head motion for the LED-matrix Snake game. It is the source end of the per-cell direction interface that the matrix cells consume.
- Converts debounced key pulses into a committed direction and advances the head one cell per game tick.
- Outputs head position, level direction lines, a one-cycle step strobe (the cells' tracking input), snake length and gameover.
- Sits between input conditioning and the matrix cell array.

---
 rtl/snake_pkg.sv | 30 +++
 rtl/snake_tick_gen.sv | 28 ++
 rtl/snake_head_driver.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake head driver.
package snake_pkg;

    localparam int LEN_W = 6;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_L,
        DIR_R,
        DIR_U,
        DIR_D
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DEAD
    } state_t;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_L:   return DIR_R;
            DIR_R:   return DIR_L;
            DIR_U:   return DIR_D;
            DIR_D:   return DIR_U;
            default: return DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Game tick generator: counts 0..TICK_DIV-1 while enabled, tc marks the last count.
module snake_tick_gen #(
    parameter int TICK_DIV = 12500000
) (
    input  logic Clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tc = en && (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/snake_head_driver.sv
// Snake head motion source: key pulses -> committed direction, one cell per tick.
// Optional macro SNAKE_WRAP_EN makes the grid edges wrap instead of ending the game.
//
// state | meaning
// IDLE  | waiting for the first key; counter held at 0
// RUN   | head advances on every tick; keys update pending direction
// DEAD  | head left the grid; everything frozen until reset
module snake_head_driver
    import snake_pkg::*;
#(
    parameter int GRID_W   = 8,
    parameter int GRID_H   = 8,
    parameter int TICK_DIV = 12500000,
    parameter int MAX_LEN  = 63,
    parameter int START_X  = 3,
    parameter int START_Y  = 3
) (
    input  logic                      Clock,
    input  logic                      reset,
    input  logic                      key_l,
    input  logic                      key_r,
    input  logic                      key_u,
    input  logic                      key_d,
    input  logic                      food_hit,
    output logic [$clog2(GRID_W)-1:0] head_x,
    output logic [$clog2(GRID_H)-1:0] head_y,
    output logic                      L,
    output logic                      R,
    output logic                      U,
    output logic                      D,
    output logic                      step,
    output logic [LEN_W-1:0]          snake_length,
    output logic                      gameover,
    output logic                      started
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

    state_t          state;
    dir_t            dir_q;
    dir_t            pend_q;
    dir_t            cand;
    dir_t            next_dir;
    logic            accept;
    logic            tick;
    logic            off_grid;
    logic            wall;
    logic [XW-1:0]   nx;
    logic [YW-1:0]   ny;

    snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .Clock (Clock),
        .reset (reset),
        .clr   (state != RUN),
        .en    (state == RUN),
        .tc    (tick)
    );

    always_comb begin
        cand = DIR_NONE;
        if (key_l)      cand = DIR_L;
        else if (key_r) cand = DIR_R;
        else if (key_u) cand = DIR_U;
        else if (key_d) cand = DIR_D;
    end

    // A press landing on the tick cycle itself still steers that tick.
    assign accept   = (cand != DIR_NONE) && (cand != opposite(dir_q));
    assign next_dir = accept ? cand : pend_q;

    always_comb begin
        nx       = head_x;
        ny       = head_y;
        off_grid = 1'b0;
        case (next_dir)
            DIR_L: begin
                if (head_x == '0) begin
                    off_grid = 1'b1;
                    nx       = XW'(GRID_W - 1);
                end else begin
                    nx = head_x - 1'b1;
                end
            end
            DIR_R: begin
                if (head_x == XW'(GRID_W - 1)) begin
                    off_grid = 1'b1;
                    nx       = '0;
                end else begin
                    nx = head_x + 1'b1;
                end
            end
            DIR_U: begin
                if (head_y == '0) begin
                    off_grid = 1'b1;
                    ny       = YW'(GRID_H - 1);
                end else begin
                    ny = head_y - 1'b1;
                end
            end
            DIR_D: begin
                if (head_y == YW'(GRID_H - 1)) begin
                    off_grid = 1'b1;
                    ny       = '0;
                end else begin
                    ny = head_y + 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign wall = 1'b0;
    logic unused_off_grid;
    assign unused_off_grid = off_grid;
`else
    assign wall = off_grid;
`endif

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            head_x       <= XW'(START_X);
            head_y       <= YW'(START_Y);
            dir_q        <= DIR_NONE;
            pend_q       <= DIR_NONE;
            step         <= 1'b0;
            snake_length <= LEN_W'(1);
            gameover     <= 1'b0;
            started      <= 1'b0;
        end else begin
            step <= 1'b0;
            if (state != DEAD && food_hit && snake_length < LEN_W'(MAX_LEN))
                snake_length <= snake_length + 1'b1;
            case (state)
                IDLE: begin
                    if (cand != DIR_NONE) begin
                        dir_q   <= cand;
                        pend_q  <= cand;
                        started <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (accept)
                        pend_q <= cand;
                    if (tick) begin
                        if (wall) begin
                            state    <= DEAD;
                            gameover <= 1'b1;
                        end else begin
                            head_x <= nx;
                            head_y <= ny;
                            dir_q  <= next_dir;
                            pend_q <= next_dir;
                            step   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign L = (dir_q == DIR_L);
    assign R = (dir_q == DIR_R);
    assign U = (dir_q == DIR_U);
    assign D = (dir_q == DIR_D);

endmodule
